com_rst_seq: RTL

- Parametrised reset sequencer: a successor to the single-bit reset synchroniser in the common CDC library.
- Synchronises an asynchronous active-low reset request into clk and stretches it to a guaranteed minimum assertion.
- Releases N_CH downstream reset outputs one at a time, in index order, with a programmable gap.
- Supports a global soft reset and per-channel soft resets. Sits at the root of each clock domain's reset tree.

---
 rtl/com_rst_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/com_rst_seq.sv
// -----------------------------------------------------------------------------
// com_rst_seq
//   Reset sequencer at the root of a clock domain's reset tree. The
//   asynchronous active-low request ireq_n is synchronised into clk and held
//   asserted for at least MIN_ASSERT quiet cycles. The N_CH reset outputs are
//   then released one at a time, in index order, GAP cycles apart. A global
//   soft reset re-enters the assert phase. Once every channel is running,
//   per-channel soft resets hold a single channel in reset for MIN_ASSERT
//   cycles.
//
//   Parameters (must satisfy): N_CH >= 1, SYNC_STAGES >= 2,
//                              MIN_ASSERT >= 1, GAP >= 1.
//
// Ports:
//   clk       in   1      block clock
//   rst_n     in   1      synchronous active-low reset
//   ireq_n    in   1      asynchronous active-low reset request, any domain
//   soft_rst  in   1      synchronous global soft-reset pulse, active-high
//   ch_rst    in   N_CH   synchronous per-channel soft-reset pulses
//   orst_n    out  N_CH   channel resets, active-low, registered
//   done      out  1      all channels released and FSM in RUN, registered
//   ostate    out  2      FSM state: 0=ASSERT, 1=RELEASE, 2=RUN
// -----------------------------------------------------------------------------
module com_rst_seq #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 16,
    parameter int GAP         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ireq_n,
    input  logic            soft_rst,
    input  logic [N_CH-1:0] ch_rst,
    output logic [N_CH-1:0] orst_n,
    output logic            done,
    output logic [1:0]      ostate
);

    localparam int MAXV  = (MIN_ASSERT > GAP) ? MIN_ASSERT : GAP;
    localparam int CW    = $clog2(MAXV + 1);
    localparam int IDX_W = $clog2(N_CH + 1);

    localparam logic [CW-1:0]    MA_TERM  = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0]    GAP_TERM = CW'(GAP - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]  r_sync;
    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           r_gcnt;
    logic [IDX_W-1:0]        r_idx;
    logic [N_CH-1:0]         r_orst_n;
    logic                    r_done;
    logic [N_CH-1:0]         r_hold;
    logic [N_CH-1:0][CW-1:0] r_hcnt;

    state_t                  w_state_nx;
    logic [CW-1:0]           w_cnt_nx;
    logic [CW-1:0]           w_gcnt_nx;
    logic [IDX_W-1:0]        w_idx_nx;
    logic [N_CH-1:0]         w_orst_nx;
    logic                    w_done_nx;
    logic [N_CH-1:0]         w_hold_nx;
    logic [N_CH-1:0][CW-1:0] w_hcnt_nx;
    logic                    w_req_sync;
    logic                    w_active;

    assign w_req_sync = r_sync[SYNC_STAGES-1];
    assign w_active   = ~w_req_sync | soft_rst;

    assign orst_n = r_orst_n;
    assign done   = r_done;
    assign ostate = r_state;

    // Synchroniser: only r_sync[0] ever samples the asynchronous request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ireq_n};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_ASSERT;
            r_cnt    <= '0;
            r_gcnt   <= '0;
            r_idx    <= '0;
            r_orst_n <= '0;
            r_done   <= 1'b0;
            r_hold   <= '0;
            r_hcnt   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_gcnt   <= w_gcnt_nx;
            r_idx    <= w_idx_nx;
            r_orst_n <= w_orst_nx;
            r_done   <= w_done_nx;
            r_hold   <= w_hold_nx;
            r_hcnt   <= w_hcnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_gcnt_nx  = r_gcnt;
        w_idx_nx   = r_idx;
        w_orst_nx  = r_orst_n;
        w_hold_nx  = r_hold;
        w_hcnt_nx  = r_hcnt;

        if (w_active) begin
            // A global request wins over everything, including ch_rst.
            w_state_nx = ST_ASSERT;
            w_cnt_nx   = '0;
            w_gcnt_nx  = '0;
            w_idx_nx   = '0;
            w_orst_nx  = '0;
            w_hold_nx  = '0;
            w_hcnt_nx  = '0;
        end else begin
            unique case (r_state)
                ST_ASSERT: begin
                    // Counter stops at the terminal value; it never wraps.
                    if (r_cnt == MA_TERM) begin
                        w_orst_nx[0] = 1'b1;
                        w_idx_nx     = IDX_ONE;
                        w_gcnt_nx    = '0;
                        w_state_nx   = (N_CH == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (r_gcnt == GAP_TERM) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (i == int'(r_idx)) begin
                                w_orst_nx[i] = 1'b1;
                            end
                        end
                        w_idx_nx  = r_idx + IDX_ONE;
                        w_gcnt_nx = '0;
                        if (int'(r_idx) == N_CH - 1) begin
                            w_state_nx = ST_RUN;
                        end
                    end else begin
                        w_gcnt_nx = r_gcnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // Each channel hold is independent; a new pulse restarts it.
                    for (int i = 0; i < N_CH; i++) begin
                        if (ch_rst[i]) begin
                            w_hold_nx[i] = 1'b1;
                            w_hcnt_nx[i] = '0;
                            w_orst_nx[i] = 1'b0;
                        end else if (r_hold[i]) begin
                            if (r_hcnt[i] == MA_TERM) begin
                                w_hold_nx[i] = 1'b0;
                                w_orst_nx[i] = 1'b1;
                            end else begin
                                w_hcnt_nx[i] = r_hcnt[i] + CNT_ONE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_ASSERT;
                    w_cnt_nx   = '0;
                    w_orst_nx  = '0;
                    w_hold_nx  = '0;
                end
            endcase
        end

        // done follows the next-state values so it moves with orst_n.
        w_done_nx = (w_state_nx == ST_RUN) && (w_hold_nx == '0);
    end

endmodule
